// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues credit-limited word
// fetches to the I$, and queues in-order responses for decode.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           QUEUE_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  output logic                   cpu_req_valid_o,
  output logic [ADDR_WIDTH-1:0]  cpu_addr_o,
  input  logic                   icache_req_ready_i,
  input  logic                   icache_resp_valid_i,
  input  logic [INSTR_WIDTH-1:0] icache_resp_instr_i,
  output logic                   cpu_resp_ready_o,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  input  logic                   instr_ready_i
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  logic                   started_q, started_d;
  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]       outst_q, outst_d;
  logic [CNT_W-1:0]       drop_q, drop_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [INSTR_WIDTH-1:0] instr_mem_q [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem_d [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem_d [QUEUE_DEPTH];

  logic [SUM_W-1:0]       in_use;
  logic [ADDR_WIDTH-1:0]  redirect_pc_aligned;
  logic                   req_valid, req_fire, push, pop;
  logic                   unused_pc_lsbs;

  // Credits: queued plus live in-flight never exceeds the queue depth.
  assign in_use              = SUM_W'(count_q) + SUM_W'(outst_q);
  assign req_valid           = started_q && !redirect_valid_i && (in_use < SUM_W'(QUEUE_DEPTH));
  assign req_fire            = req_valid && icache_req_ready_i;
  assign push                = icache_resp_valid_i && (drop_q == '0) && !redirect_valid_i;
  assign pop                 = (count_q != '0) && instr_ready_i;
  assign redirect_pc_aligned = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign unused_pc_lsbs      = ^redirect_pc_i[1:0];

  assign cpu_req_valid_o  = req_valid;
  assign cpu_addr_o       = fetch_pc_q;
  assign cpu_resp_ready_o = 1'b1;
  assign instr_valid_o    = (count_q != '0);
  assign instr_o          = instr_mem_q[rd_ptr_q];
  assign instr_pc_o       = pc_mem_q[rd_ptr_q];

  always_comb begin
    started_d   = 1'b1;
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    outst_d     = outst_q;
    drop_d      = drop_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;

    if (redirect_valid_i) begin
      // Everything live in flight turns stale; an arriving response consumes one.
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      drop_d     = drop_q + outst_q - CNT_W'(icache_resp_valid_i);
      outst_d    = '0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (icache_resp_valid_i && (drop_q != '0)) begin
        drop_d = drop_q - CNT_W'(1);
      end
      if (push) begin
        instr_mem_d[wr_ptr_q] = icache_resp_instr_i;
        pc_mem_d[wr_ptr_q]    = resp_pc_q;
        resp_pc_d             = resp_pc_q + PC_STEP;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(push);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      started_q   <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      outst_q     <= '0;
      drop_q      <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      instr_mem_q <= '{default: '0};
      pc_mem_q    <= '{default: RESET_PC};
    end else begin
      started_q   <= started_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model of the fetch stream (queued PCs,
// in-flight requests tagged live/stale) plus a behavioural I$ with variable latency.
module tb_fetch_unit;

  localparam int unsigned AW  = 32;
  localparam int unsigned IW  = 32;
  localparam int unsigned QD  = 4;
  localparam logic [31:0] RPC = 32'h0000_1000;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          redirect_valid_i;
  logic [AW-1:0] redirect_pc_i;
  logic          cpu_req_valid_o;
  logic [AW-1:0] cpu_addr_o;
  logic          icache_req_ready_i;
  logic          icache_resp_valid_i;
  logic [IW-1:0] icache_resp_instr_i;
  logic          cpu_resp_ready_o;
  logic          instr_valid_o;
  logic [IW-1:0] instr_o;
  logic [AW-1:0] instr_pc_o;
  logic          instr_ready_i;

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .RESET_PC   (RPC),
    .QUEUE_DEPTH(QD)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .redirect_valid_i   (redirect_valid_i),
    .redirect_pc_i      (redirect_pc_i),
    .cpu_req_valid_o    (cpu_req_valid_o),
    .cpu_addr_o         (cpu_addr_o),
    .icache_req_ready_i (icache_req_ready_i),
    .icache_resp_valid_i(icache_resp_valid_i),
    .icache_resp_instr_i(icache_resp_instr_i),
    .cpu_resp_ready_o   (cpu_resp_ready_o),
    .instr_valid_o      (instr_valid_o),
    .instr_o            (instr_o),
    .instr_pc_o         (instr_pc_o),
    .instr_ready_i      (instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] pc; bit stale; } infl_t;
  typedef struct { logic [31:0] data; int due; } icreq_t;

  logic [31:0] exp_q [$];
  infl_t       infl [$];
  icreq_t      ic_q [$];
  logic [31:0] fetch_pc_m;
  bit          started_m;
  int          cyc;

  bit          redir_en;
  logic [31:0] redir_pc;
  bit          dec_ready;
  bit          ic_ready;
  int          lat;

  int n_checks;
  int n_errors;
  int n_hs;

  // Memory contents as seen by the I$: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hA5C3_0F96;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    infl.delete();
    ic_q.delete();
    fetch_pc_m = RPC;
    started_m  = 1'b0;
  endtask

  function automatic int live_count();
    int n = 0;
    foreach (infl[i]) if (!infl[i].stale) n++;
    return n;
  endfunction

  // One clock cycle: drive at negedge, check before posedge, advance model after it.
  task automatic cycle();
    bit          resp, exp_rv, hs, hs_m, pop_m;
    logic [31:0] req_addr;
    infl_t       f;
    icreq_t      r;
    @(negedge clk_i);
    redirect_valid_i    = redir_en;
    redirect_pc_i       = redir_pc;
    instr_ready_i       = dec_ready;
    icache_req_ready_i  = ic_ready;
    resp                = (ic_q.size() > 0) && (ic_q[0].due <= cyc);
    icache_resp_valid_i = resp;
    icache_resp_instr_i = resp ? ic_q[0].data : 32'h0;
    #1;
    exp_rv = started_m && !redir_en && ((exp_q.size() + live_count()) < QD);
    check("req_valid", 64'(cpu_req_valid_o), 64'(exp_rv));
    check("req_addr", 64'(cpu_addr_o), 64'(fetch_pc_m));
    check("resp_ready", 64'(cpu_resp_ready_o), 64'd1);
    check("instr_valid", 64'(instr_valid_o), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("instr_pc", 64'(instr_pc_o), 64'(exp_q[0]));
      check("instr_data", 64'(instr_o), 64'(mem_word(exp_q[0])));
    end
    hs       = cpu_req_valid_o && icache_req_ready_i;
    req_addr = cpu_addr_o;
    hs_m     = exp_rv && ic_ready;
    pop_m    = (exp_q.size() != 0) && dec_ready;
    @(posedge clk_i);
    // I$ side: consume presented response, accept new request.
    if (resp) void'(ic_q.pop_front());
    if (hs) begin
      n_hs++;
      r.data = mem_word(req_addr);
      r.due  = cyc + lat;
      if (ic_q.size() > 0 && r.due < ic_q[$].due) r.due = ic_q[$].due;
      ic_q.push_back(r);
    end
    // Reference fetch stream.
    if (redir_en) begin
      exp_q.delete();
      if (resp && infl.size() > 0) void'(infl.pop_front());
      foreach (infl[i]) infl[i].stale = 1'b1;
      fetch_pc_m = {redir_pc[31:2], 2'b00};
    end else begin
      if (pop_m) void'(exp_q.pop_front());
      if (resp && infl.size() > 0) begin
        f = infl.pop_front();
        if (!f.stale) exp_q.push_back(f.pc);
      end
      if (hs_m) begin
        f.pc    = fetch_pc_m;
        f.stale = 1'b0;
        infl.push_back(f);
        fetch_pc_m = fetch_pc_m + 32'd4;
      end
    end
    started_m = 1'b1;
    cyc++;
  endtask

  task automatic drain();
    bit done = 1'b0;
    redir_en  = 1'b0;
    ic_ready  = 1'b0;
    dec_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (ic_q.size() == 0 && infl.size() == 0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      cycle();
    end
    check("drain_done", 64'(done), 64'd1);
  endtask

  initial begin
    bit found;
    n_checks = 0;
    n_errors = 0;
    n_hs     = 0;
    cyc      = 0;
    rst_i    = 1'b1;
    redirect_valid_i    = 1'b0;
    redirect_pc_i       = '0;
    icache_req_ready_i  = 1'b0;
    icache_resp_valid_i = 1'b0;
    icache_resp_instr_i = '0;
    instr_ready_i       = 1'b0;
    redir_en  = 1'b0;
    redir_pc  = '0;
    dec_ready = 1'b1;
    ic_ready  = 1'b1;
    lat       = 1;
    reset_model();

    #1;
    check("rst_req_valid", 64'(cpu_req_valid_o), 64'd0);
    check("rst_req_addr", 64'(cpu_addr_o), 64'(RPC));
    check("rst_instr_valid", 64'(instr_valid_o), 64'd0);
    check("rst_instr", 64'(instr_o), 64'd0);
    check("rst_instr_pc", 64'(instr_pc_o), 64'(RPC));
    check("rst_resp_ready", 64'(cpu_resp_ready_o), 64'd1);
    @(posedge clk_i);
    #2 rst_i = 1'b0;

    // Sustained streaming with a 1-cycle I$.
    repeat (20) cycle();

    // Decode stalled: exactly QD requests accepted, then drain and resume.
    drain();
    n_hs      = 0;
    dec_ready = 1'b0;
    ic_ready  = 1'b1;
    repeat (10) cycle();
    check("stall_accepts", 64'(n_hs), 64'(QD));
    dec_ready = 1'b1;
    repeat (12) cycle();

    // I$ request channel stalled.
    ic_ready = 1'b0;
    repeat (5) cycle();
    ic_ready = 1'b1;
    repeat (10) cycle();

    // Redirect with two requests in flight, 3-cycle I$.
    drain();
    lat      = 3;
    ic_ready = 1'b1;
    repeat (2) cycle();
    ic_ready = 1'b0;
    check("two_inflight", 64'(infl.size()), 64'd2);
    redir_en = 1'b1;
    redir_pc = 32'h0000_2002;
    cycle();
    redir_en = 1'b0;
    ic_ready = 1'b1;
    repeat (15) cycle();

    // Redirect coinciding with a response, one more still in flight.
    drain();
    lat      = 3;
    ic_ready = 1'b1;
    repeat (2) cycle();
    ic_ready = 1'b0;
    found    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (ic_q.size() == 2 && ic_q[0].due <= cyc) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check("resp_redirect_setup", 64'(found), 64'd1);
    redir_en = 1'b1;
    redir_pc = 32'h0000_3000;
    cycle();
    redir_en = 1'b0;
    ic_ready = 1'b1;
    lat      = 1;
    repeat (12) cycle();

    // PC wrap-around.
    redir_en = 1'b1;
    redir_pc = 32'hFFFF_FFF6;
    cycle();
    redir_en = 1'b0;
    repeat (12) cycle();

    // Randomized traffic including back-to-back and accumulating redirects.
    repeat (600) begin
      dec_ready = ($urandom_range(3, 0) != 0);
      ic_ready  = ($urandom_range(9, 0) < 7);
      lat       = int'($urandom_range(3, 1));
      redir_en  = ($urandom_range(99, 0) < 5);
      redir_pc  = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom();
      cycle();
    end
    redir_en = 1'b0;

    // Asynchronous reset with three instructions queued.
    dec_ready = 1'b0;
    ic_ready  = 1'b1;
    lat       = 1;
    found     = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 3) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check("queue_three_setup", 64'(found), 64'd1);
    @(negedge clk_i);
    icache_resp_valid_i = 1'b0;
    redirect_valid_i    = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("midrst_instr_valid", 64'(instr_valid_o), 64'd0);
    check("midrst_req_valid", 64'(cpu_req_valid_o), 64'd0);
    check("midrst_req_addr", 64'(cpu_addr_o), 64'(RPC));
    check("midrst_instr_pc", 64'(instr_pc_o), 64'(RPC));
    reset_model();
    dec_ready = 1'b1;
    ic_ready  = 1'b1;
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    repeat (20) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that sits directly upstream of the instruction cache. It owns the fetch PC and issues sequential word fetches to the I$ over a valid/ready request channel. In-order I$ responses land in a small instruction queue that feeds decode. Credit-based issue guarantees every response has a free queue slot. A redirect (branch/exception/FENCE.I restart) discards queued and in-flight instructions.

## Interface
Parameters:
- ADDR_WIDTH, 32: fetch address width
- INSTR_WIDTH, 32: instruction width
- RESET_PC, 32'h0000_0000: first fetch address after reset
- QUEUE_DEPTH, 4: instruction queue entries; power of 2, ≥2

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- redirect_valid_i  in  1  one-cycle redirect request
- redirect_pc_i  in  ADDR_WIDTH  new fetch PC; bits [1:0] ignored (treated as 0)
- cpu_req_valid_o  out  1  fetch request to I$
- cpu_addr_o  out  ADDR_WIDTH  fetch address
- icache_req_ready_i  in  1  I$ accepts request
- icache_resp_valid_i  in  1  I$ response valid
- icache_resp_instr_i  in  INSTR_WIDTH  response instruction
- cpu_resp_ready_o  out  1  tied 1; credits guarantee space
- instr_valid_o  out  1  queue head valid to decode
- instr_o  out  INSTR_WIDTH  queue head instruction
- instr_pc_o  out  ADDR_WIDTH  PC of queue head
- instr_ready_i  in  1  decode accepts head

## Operation
- State: fetch_pc, resp_pc, outstanding counter (live in-flight), drop counter (stale in-flight), queue with count. Counters are $clog2(QUEUE_DEPTH)+1 bits wide.
- Issue: cpu_req_valid_o = !redirect_valid_i && (count + outstanding < QUEUE_DEPTH). cpu_addr_o = fetch_pc. On handshake (valid && ready): fetch_pc += 4, outstanding +1.
- cpu_addr_o and cpu_req_valid_o stay stable while waiting on icache_req_ready_i, unless a redirect occurs.
- Response handling:
  - drop > 0: the response is discarded and drop decrements.
  - drop == 0: {resp_pc, instr} is pushed into the queue, resp_pc += 4, outstanding decrements.
- Pop: on instr_valid_o && instr_ready_i. A push and a pop may occur in the same cycle; count is unchanged.
- Redirect in cycle N, applied at the edge ending N:
  - queue emptied;
  - fetch_pc and resp_pc take {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  - drop takes drop + outstanding, minus 1 if a response arrives in N;
  - outstanding goes to 0.
  - A response arriving in N is never queued. A decode pop in N has no further effect.
- PC arithmetic wraps modulo 2^ADDR_WIDTH (0xFFFF_FFFC + 4 → 0x0).
- Invariant: count + outstanding ≤ QUEUE_DEPTH. Pushes never overflow the queue.
- Responses are assumed in order, one per accepted request; the I$ handles FENCE.I flushing separately.

## Timing
- Reset values (async, immediate):
  - cpu_req_valid_o = 0, cpu_addr_o = RESET_PC
  - instr_valid_o = 0, instr_o = 0, instr_pc_o = RESET_PC
  - all counters 0
  - cpu_resp_ready_o = 1
- Reset deasserted before edge E: cpu_req_valid_o = 1 in the cycle after E.
- Response latency: a response accepted in cycle T is visible at instr_valid_o in T+1. No same-cycle bypass.
- Throughput: 1 instruction/cycle sustained with a 1-cycle I$ and decode always ready.
- Redirect in cycle N:
  - cpu_req_valid_o = 0 in N;
  - instr_valid_o = 0 in N+1;
  - the request for the new PC is presented in N+1.
- A second redirect while drop > 0 accumulates correctly.
- Reset asserted mid-operation clears all state, including drop and outstanding. The bench must also reset the I$.

## Test plan
- Reset release, RESET_PC=0x1000, I$ always ready with 1-cycle response → instr_pc_o sequence 0x1000, 0x1004, 0x1008…; instr_valid_o continuously high from its first assertion.
- instr_ready_i held 0 with DEPTH=4 → exactly 4 requests accepted, then cpu_req_valid_o=0. Releasing instr_ready_i → 4 instructions drain in order, then fetch resumes at 0x1010.
- icache_req_ready_i low for 5 cycles → cpu_addr_o held constant, no queue change, fetch resumes with no skipped PC.
- Two requests outstanding (3-cycle I$ latency), redirect to 0x2002 → both stale responses dropped, queue empty, next cpu_addr_o 0x2000, first instr_pc_o 0x2000.
- Redirect in the same cycle as a response arrival with one more outstanding → neither response queued, drop = 1 afterward, the post-redirect instruction has the correct PC.
- Async reset asserted mid-stream with the queue at 3 entries → instr_valid_o and cpu_req_valid_o drop immediately; after release, fetch restarts at RESET_PC.
